avg_diff_monitor: RTL
=====================

// Module: avg_diff_monitor
// PURPOSE
//  Downstream consumer of the 4-sample serial averager. Captures the averager's avg/diff outputs on each done pulse.
//  Runs a hysteretic over-deviation alarm FSM on diff and keeps frame statistics: count, min/max of avg.
//  Also flags protocol violations on the done strobe. Drives the alarm/status interface of the datapath.
// PARAMETERS
//  THRESH  16  diff threshold; a frame is "high" when diff_in > THRESH
//  HYST    4   hysteresis; a frame is "low" when diff_in < THRESH-HYST (HYST<=THRESH required)
//  N_SET   3   consecutive high frames needed to raise the alarm (>=1)
//  N_CLR   2   consecutive low frames needed to clear the alarm (>=1)
//  CNT_W   16  width of the frame counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  done       in   1      averager done; high 1 cycle per 4-cycle frame
//  avg_in     in   8      averager avg output, valid while done=1
//  diff_in    in   8      averager |sample-avg| output, valid while done=1
//  clr_stats  in   1      sync clear of frame_cnt/avg_min/avg_max/proto_err
//  out_vld    out  1      1-cycle pulse, cycle after each accepted frame
//  avg_q      out  8      registered avg of last accepted frame
//  diff_q     out  8      registered diff of last accepted frame
//  alarm      out  1      alarm level
//  frame_cnt  out  CNT_W  accepted frames; saturates at all-ones
//  avg_min    out  8      min avg since reset/clear
//  avg_max    out  8      max avg since reset/clear
//  proto_err  out  1      sticky: done was high on consecutive cycles
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_vld/alarm/proto_err=0, avg_q=diff_q=0, frame_cnt=0, avg_min=8'hFF, avg_max=0.
//   - FSM=ARM; internal over_cnt/under_cnt=0.
//  Accept:
//   - done=1 and done was 0 the previous cycle.
//   - done=1 on consecutive cycles: 2nd+ cycles ignored; proto_err set the cycle after.
//  FSM states ARM, CLEAR, ALARM:
//   - ARM: first accepted done after reset is consumed without capture (averager outputs not yet valid).
//     -> CLEAR; no out_vld, no stats update.
//   - CLEAR (alarm=0), per accepted frame:
//     high: over_cnt+1; otherwise over_cnt=0.
//     over_cnt reaching N_SET -> ALARM; over_cnt=0.
//   - ALARM (alarm=1), per accepted frame:
//     low: under_cnt+1; otherwise under_cnt=0.
//     under_cnt reaching N_CLR -> CLEAR; under_cnt=0.
//     Frames in the [THRESH-HYST, THRESH] band reset the run counters.
//  Timing and outputs:
//   - alarm, avg_q, diff_q, out_vld, frame_cnt, min/max all update on the edge ending the accept cycle (latency 1).
//   - frame_cnt saturates at all-ones; no wrap.
//   - Compares: avg_min=min(avg_min,avg_in), avg_max=max(...); unsigned, 8-bit.
//  clr_stats:
//   - Alone: frame_cnt=0, avg_min=FF, avg_max=0, proto_err=0.
//   - Same cycle as an accept: clear then capture, giving frame_cnt=1 and avg_min=avg_max=avg_in.
//   - Never alters FSM or alarm.
//   - Coincident with a proto error: proto_err ends at 1 (set wins).
//  Reset mid-frame: all state to reset values; re-enters ARM and discards the next done.
// TESTING
//  - Reset, then done pulses every 4 cycles (first avg=0/diff=0, then avg=40/diff=5):
//    first pulse gives no out_vld; second gives out_vld, avg_q=40, frame_cnt=1.
//  - diff sequence 20,20,20 (THRESH=16):
//    alarm rises 1 cycle after the 3rd frame; with 20,20,15,20 alarm stays 0.
//  - In ALARM, diff 11,11: alarm clears after the 2nd frame. 11,14,11: stays 1 (14 in band resets under_cnt).
//  - avg 40,10,200: avg_min=10, avg_max=200.
//    clr_stats with accept avg=77 gives min=max=77, frame_cnt=1.
//  - done held high 2 cycles: one frame accepted, proto_err=1 and sticky until clr_stats.
//  - rst_n low mid-ALARM: alarm=0 immediately (async); next done discarded (ARM).
//    Force frame_cnt near all-ones: saturates, no wrap.

Source files
------------

// File: rtl/avg_diff_monitor.sv
// avg_diff_monitor: consumes the 4-sample averager's avg/diff on each done pulse,
// runs a hysteretic over-deviation alarm, keeps frame statistics and flags
// done-strobe protocol violations.
module avg_diff_monitor #(
  parameter int unsigned THRESH = 16,
  parameter int unsigned HYST   = 4,
  parameter int unsigned N_SET  = 3,
  parameter int unsigned N_CLR  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic [7:0]       avg_in,
  input  logic [7:0]       diff_in,
  input  logic             clr_stats,
  output logic             out_vld,
  output logic [7:0]       avg_q,
  output logic [7:0]       diff_q,
  output logic             alarm,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       avg_min,
  output logic [7:0]       avg_max,
  output logic             proto_err
);

  localparam int unsigned OW = (N_SET > 1) ? $clog2(N_SET + 1) : 1;
  localparam int unsigned UW = (N_CLR > 1) ? $clog2(N_CLR + 1) : 1;
  localparam logic [7:0] HighLim = 8'(THRESH);
  localparam logic [7:0] LowLim  = 8'(THRESH - HYST);

  typedef enum logic [1:0] {StArm, StClear, StAlarm} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   over_q, over_d;
  logic [UW-1:0]   under_q, under_d;
  logic            done_q;

  logic             accept, capture, is_high, is_low;
  logic             out_vld_d, proto_err_d;
  logic [7:0]       avg_d, diff_d, avg_min_d, avg_max_d;
  logic [CNT_W-1:0] frame_cnt_d;

  // Only the rising edge of done is a frame; held-high cycles are ignored.
  assign accept  = done & ~done_q;
  // The very first frame after reset carries stale averager data and is dropped.
  assign capture = accept & (state_q != StArm);
  assign is_high = diff_in > HighLim;
  assign is_low  = diff_in < LowLim;
  assign alarm   = (state_q == StAlarm);

  // Alarm FSM next-state and run counters; band frames reset the active run.
  always_comb begin
    state_d = state_q;
    over_d  = over_q;
    under_d = under_q;
    unique case (state_q)
      StArm: begin
        if (accept) state_d = StClear;
      end
      StClear: begin
        if (accept) begin
          if (is_high) begin
            if (over_q == OW'(N_SET - 1)) begin
              state_d = StAlarm;
              over_d  = '0;
            end else begin
              over_d = over_q + OW'(1);
            end
          end else begin
            over_d = '0;
          end
        end
      end
      StAlarm: begin
        if (accept) begin
          if (is_low) begin
            if (under_q == UW'(N_CLR - 1)) begin
              state_d = StClear;
              under_d = '0;
            end else begin
              under_d = under_q + UW'(1);
            end
          end else begin
            under_d = '0;
          end
        end
      end
      default: state_d = StArm;
    endcase
  end

  // Statistics next-state: clear first so a coincident capture lands on fresh values.
  always_comb begin
    out_vld_d   = capture;
    avg_d       = avg_q;
    diff_d      = diff_q;
    frame_cnt_d = frame_cnt;
    avg_min_d   = avg_min;
    avg_max_d   = avg_max;
    proto_err_d = proto_err;
    if (clr_stats) begin
      frame_cnt_d = '0;
      avg_min_d   = 8'hFF;
      avg_max_d   = 8'h00;
      proto_err_d = 1'b0;
    end
    if (capture) begin
      avg_d  = avg_in;
      diff_d = diff_in;
      if (frame_cnt_d != {CNT_W{1'b1}}) frame_cnt_d = frame_cnt_d + CNT_W'(1);
      if (avg_in < avg_min_d) avg_min_d = avg_in;
      if (avg_in > avg_max_d) avg_max_d = avg_in;
    end
    // Set wins over a same-cycle clear.
    if (done && done_q) proto_err_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StArm;
      over_q    <= '0;
      under_q   <= '0;
      done_q    <= 1'b0;
      out_vld   <= 1'b0;
      avg_q     <= 8'h00;
      diff_q    <= 8'h00;
      frame_cnt <= '0;
      avg_min   <= 8'hFF;
      avg_max   <= 8'h00;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      over_q    <= over_d;
      under_q   <= under_d;
      done_q    <= done;
      out_vld   <= out_vld_d;
      avg_q     <= avg_d;
      diff_q    <= diff_d;
      frame_cnt <= frame_cnt_d;
      avg_min   <= avg_min_d;
      avg_max   <= avg_max_d;
      proto_err <= proto_err_d;
    end
  end

endmodule
